// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the serial receiver.
package uart_pkg;

    localparam int unsigned BAUD_DEFAULT = 1250;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_W     = $clog2(DATA_BITS);
    localparam logic        START_LVL = 1'b0;
    localparam logic        STOP_LVL  = 1'b1;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

endpackage

// File: rtl/baud_tick_rx.sv
// Bit-period down-counter: strobes tick when it reaches zero while enabled.
module baud_tick_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD = BAUD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic half,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(BAUD);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD / 2 - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = ena && (cnt == '0);

    // Preload while disabled; wrap to a full bit period on every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= HALF_LOAD;
        end else if (!ena) begin
            cnt <= half ? HALF_LOAD : FULL_LOAD;
        end else if (cnt == '0) begin
            cnt <= FULL_LOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/recibir.sv
// 8N1 serial receiver: parallel byte with rcv strobe, ferr on bad stop bit.
module recibir
    import uart_pkg::*;
#(
    parameter int unsigned BAUD = BAUD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rcv,
    output logic                 ferr,
    output logic                 busy
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    state_t               state;
    logic [1:0]           rx_sync;
    logic                 rx_s;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shifter;
    logic                 tick;
    logic                 cnt_ena;
    logic                 cnt_half;

    assign rx_s     = rx_sync[1];
    assign cnt_ena  = (state == START) || (state == DATA) || (state == STOP);
    assign cnt_half = (state == IDLE) || (state == BRK);

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    baud_tick_rx #(
        .BAUD (BAUD)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .ena  (cnt_ena),
        .half (cnt_half),
        .tick (tick)
    );

    // Frame FSM with shifter and registered outputs; rcv/ferr default low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shifter <= '0;
            data    <= '0;
            rcv     <= 1'b0;
            ferr    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rcv  <= 1'b0;
            ferr <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_s == START_LVL) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s == START_LVL) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shifter <= {rx_s, shifter[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s == STOP_LVL) begin
                            data  <= shifter;
                            rcv   <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            ferr  <= 1'b1;
                            state <= BRK;
                        end
                    end
                end
                BRK: begin
                    // Hold off until the line returns high so a break is not read as frames.
                    if (rx_s == STOP_LVL) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/recibir.md
Name: recibir

Overview:
- Serial receiver for 8N1 asynchronous frames on the line arriving from the PC: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Companion of the serial transmitter in the same design; both use the same BAUD parameter.
- Presents each received byte on a parallel bus with a one-cycle valid strobe, and flags frames whose stop bit is bad.

Parameters:
- BAUD, 1250, clock cycles per bit period; must be ≥ 4 and even.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx  in  1  serial input, asynchronous to clk, idles at 1
- data  out  8  last correctly received byte
- rcv  out  1  one-cycle pulse: new byte on data
- ferr  out  1  one-cycle pulse: framing error (stop bit sampled 0)
- busy  out  1  1 while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset: asynchronous and active-high. Reset values: data=8'h00, rcv=0, ferr=0, busy=0, state=IDLE, synchronizer=2'b11, bit counter=0, shifter=8'h00.
- Input sync: rx passes through 2 flip-flops to give rx_s. All decisions use rx_s only.
- Tick counter:
  - Reloads with BAUD/2-1 on entry to START.
  - Reloads with BAUD-1 on each tick inside DATA/STOP.
  - Tick = one-cycle strobe when the counter reaches 0; the counter holds while in IDLE.
- States:
  - IDLE: stays while rx_s=1. On rx_s=0, go to START and load the half-bit count.
  - START: on tick, sample rx_s.
    - rx_s=1: glitch; return to IDLE with no outputs.
    - rx_s=0: go to DATA, bit counter=0.
  - DATA: on each tick, shifter <= {rx_s, shifter[7:1]} and the bit counter increments. After the 8th sample, go to STOP.
  - STOP: on tick, sample rx_s.
    - rx_s=1: data <= shifter, rcv=1 for exactly the next cycle, go to IDLE.
    - rx_s=0: ferr=1 for exactly the next cycle, data unchanged, go to BRK.
  - BRK: wait for rx_s=1, then go to IDLE. This stops a break or stuck-low line from producing false frames.
- Sampling points: start sample falls BAUD/2 cycles after the falling edge is seen in rx_s. Each later sample is BAUD cycles after the previous one (mid-bit).
- Latency: rcv rises 1 cycle after the stop-bit sample cycle, about 9.5·BAUD+3 cycles after the rx falling edge.
- rcv and ferr are never high in the same cycle. rcv is never asserted for a glitch-rejected start.
- data holds its value between frames. There is no handshake: the consumer must capture data on rcv. A new frame simply overwrites data at its own rcv.
- Back-to-back frames: a start bit that follows a stop bit immediately must be detected. IDLE is entered in the cycle after the stop sample, and the remaining half stop bit gives enough margin.
- Reset mid-frame: aborts immediately, no rcv/ferr, reception resumes from IDLE.
- busy=1 in START, DATA, STOP and BRK.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, BRK=4; 3 bits);
  - default BAUD value 1250;
  - frame constants: DATA_BITS=8, START_LVL=0, STOP_LVL=1.
- One sub-module, `baud_tick_rx`:
  - down-counter with parameter BAUD;
  - inputs: clk, rst, ena, half (load BAUD/2-1 instead of BAUD-1 on restart);
  - output: tick.
  - Counts only while ena=1 and reloads when ena=0.
- The FSM, synchronizer, shifter and output registers stay in `recibir`.

Test Plan (BAUD=8 unless stated):
- Byte 8'hA5 sent as 8N1 at 8 clk/bit → one rcv pulse of exactly 1 cycle, data=8'hA5, ferr never 1, busy back to 0 after the stop sample.
- Bytes 8'h00 then 8'hFF back-to-back with no idle gap → two rcv pulses; data=8'h00 at the first and 8'hFF at the second.
- rx low for 2 cycles then high → no rcv, no ferr; busy=1 for BAUD/2 cycles, then 0.
- Frame 8'h3C with stop bit forced 0, then line held low for 30 cycles, then high → one ferr pulse; data keeps its previous value; busy stays 1 until rx_s=1; no rcv.
- rst pulsed during data bit 4 of a frame → all outputs go to reset values asynchronously; a following clean frame 8'h5A → rcv with data=8'h5A.
- BAUD=1250, byte 8'h41 with transmitter bit period 2% fast and 2% slow → data=8'h41 in both cases.
